// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle adder responder. Accepts one WIDTH-bit add request over a
//   valid/ready handshake, sums it one 4-bit slice per clock through a
//   carry-lookahead nibble adder (LSB nibble first), then presents {cout, s}
//   over a second valid/ready handshake and counts completed results.
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   reset       asynchronous active-low reset
//   in_valid    request valid           in_ready   block idle, can accept
//   a, b, cin   operands / carry in
//   out_valid   result valid            out_ready  consumer takes result
//   s, cout     sum and carry out (qualify with out_valid)
//   done_count  completed output handshakes, wraps
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// RUN   | one nibble summed per clock, NIB clocks total
// DONE  | result held with out_valid high until out_ready
module nibble_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [CNT_W-1:0] done_count
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;

  logic [3:0] a_nib, b_nib, g, p, c_vec, sum4;
  logic       c4;

  // Select the active nibble of each captured operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[n*4 +: 4];
        b_nib = b_q[n*4 +: 4];
      end
    end
  end

  // 4-bit carry-lookahead: every carry is formed directly from g/p and carry_q.
  always_comb begin
    g        = a_nib & b_nib;
    p        = a_nib ^ b_nib;
    c_vec[0] = carry_q;
    c_vec[1] = g[0] | (p[0] & carry_q);
    c_vec[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c_vec[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
    c4       = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
    sum4     = p ^ c_vec;
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    s_d          = s_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    out_valid_d  = out_valid_q;
    idx_d        = idx_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          s_d     = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) s_d[n*4 +: 4] = sum4;
        end
        carry_d = c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          cout_d      = c4;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          done_count_d = done_count_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      s_q          <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      idx_q        <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      s_q          <= s_d;
      carry_q      <= carry_d;
      cout_q       <= cout_d;
      out_valid_q  <= out_valid_d;
      idx_q        <= idx_d;
      done_count_q <= done_count_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign s          = s_q;
  assign cout       = cout_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, s;
  logic [7:0]  done_count;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0]  a4, b4, s4;
  logic [7:0]  done_count4;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          n_sent = 0;
  logic [16:0] sb_q[$];
  logic [4:0]  sb4_q[$];

  nibble_serial_adder #(.WIDTH(16), .CNT_W(8)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .done_count(done_count)
  );

  nibble_serial_adder #(.WIDTH(4), .CNT_W(8)) dut4 (
    .CLK(CLK), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .cout(cout4), .done_count(done_count4)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitors: pop one expectation per observed output handshake.
  always @(negedge CLK) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("w16 unexpected result", {cout, s}, 17'h1ffff ^ {cout, s});
      else check("w16 result", {cout, s}, sb_q.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (reset && out_valid4 && out_ready4) begin
      if (sb4_q.size() == 0) check("w4 unexpected result", {cout4, s4}, 5'h1f ^ {cout4, s4});
      else check("w4 result", {cout4, s4}, sb4_q.pop_front());
    end
  end

  task automatic wait_in_ready();
    int k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  // Issue one request, scramble inputs during RUN, check latency, consume.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input logic [16:0] exp, input string name);
    int lat;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    wait_in_ready();
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    wait_out(lat);
    check({name, " latency"}, 64'(lat), 64'd4);
    tick();
    n_sent++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end, got running, expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, prev_acc;
    logic [15:0] ra, rb;
    logic        rc;

    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    tick(); tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset s", 64'(s), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset done_count", 64'(done_count), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    tick();

    // Full carry ripple and all-ones
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "ripple");
    send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "all ones");
    // Mixed operands, inputs zeroed during RUN inside send
    send(16'h1234, 16'h4321, 1'b1, 17'h05556, "mixed");
    send(16'h8000, 16'h8000, 1'b0, 17'h10000, "msb carry");
    check("done_count after 4", 64'(done_count), 64'd4);

    // Backpressure with a pending new request on the inputs
    out_ready = 1'b0;
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
    wait_in_ready();
    sb_q.push_back(17'h01000);
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    wait_out(lat);
    check("bp latency", 64'(lat), 64'd4);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp s", 64'(s), 64'h1000);
      check("bp cout", 64'(cout), 64'd0);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp done_count", 64'(done_count), 64'(n_sent));
      tick();
    end
    out_ready = 1'b1;
    sb_q.push_back(17'h0FFFF);
    tick();
    n_sent++;
    check("bp release out_valid", 64'(out_valid), 64'd0);
    check("bp release done_count", 64'(done_count), 64'(n_sent));
    check("bp release in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    wait_out(lat);
    check("bp next latency", 64'(lat), 64'd4);
    tick();
    n_sent++;
    check("done_count after bp", 64'(done_count), 64'd6);

    // Reset in the middle of RUN
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    wait_in_ready();
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("midrun out_valid", 64'(out_valid), 64'd0);
    check("midrun s", 64'(s), 64'd0);
    check("midrun cout", 64'(cout), 64'd0);
    check("midrun done_count", 64'(done_count), 64'd0);
    n_sent = 0;
    tick();
    reset = 1'b1;
    #2;
    check("post reset in_ready", 64'(in_ready), 64'd1);
    check("post reset no output", 64'(out_valid), 64'd0);
    send(16'h0003, 16'h0004, 1'b0, 17'h00007, "after reset");

    // Back-to-back random run from a fresh count
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      wait_in_ready();
      sb_q.push_back({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
      tick();
      if (i > 0) check("b2b spacing", 64'(cyc - prev_acc), 64'd6);
      prev_acc = cyc;
      if (i == 299) in_valid = 1'b0;
    end
    wait_out(lat);
    check("b2b last latency", 64'(lat), 64'd4);
    tick();
    check("b2b done_count", 64'(done_count), 64'd44);
    check("b2b final in_ready", 64'(in_ready), 64'd1);

    // WIDTH=4 instance
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; in_valid4 = 1'b1;
    check("w4 in_ready", 64'(in_ready4), 64'd1);
    sb4_q.push_back(5'h1F);
    tick();
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    check("w4 not yet valid", 64'(out_valid4), 64'd0);
    tick();
    check("w4 valid after 1 edge", 64'(out_valid4), 64'd1);
    tick();
    check("w4 done_count", 64'(done_count4), 64'd1);

    tick();
    check("w16 scoreboard drained", 64'(sb_q.size()), 64'd0);
    check("w4 scoreboard drained", 64'(sb4_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
